collision_engine: RTL and testbench

Sequential, parametrised collision resolver for the tank game: supports NUM_TANKS tanks/bullets and NUM_WALLS walls of either orientation.
- On each frame_start pulse it snapshots all positions, scans walls and bullet/tank pairs one index per cycle, then publishes registered results with a done pulse.
- Adds screen-edge blocking, overlap-based (non-equality) hit tests, and sticky per-tank alive flags cleared only by round_clear.
- Sits between the tank/bullet motion controllers and the game-state FSM.

---
 rtl/collision_engine_if.sv | 43 ++++
 rtl/collision_engine.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_collision_engine.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/collision_engine_if.sv
// ----------------------------------------------------------------------------
// collision_engine_if
// Bundles the frame control strobes, the wall/tank/bullet position buses and
// the per-frame results exchanged between the game logic and collision_engine.
//   master : drives frame_start, round_clear and all positions/directions;
//            receives busy, done, can_move, bullet_hit, tank_alive
//   slave  : the collision engine side (mirror of master)
// Field k of a packed bus sits at [k*COORD_W +: COORD_W] (directions: [k*3 +: 3]).
// ----------------------------------------------------------------------------
interface collision_engine_if #(
   parameter int NUM_TANKS = 2,
   parameter int NUM_WALLS = 4,
   parameter int COORD_W   = 10
);
   logic                         frame_start;
   logic                         round_clear;
   logic [NUM_WALLS*COORD_W-1:0] wall_x;
   logic [NUM_WALLS*COORD_W-1:0] wall_y;
   logic [NUM_WALLS-1:0]         wall_vert;
   logic [NUM_TANKS*COORD_W-1:0] tank_x;
   logic [NUM_TANKS*COORD_W-1:0] tank_y;
   logic [NUM_TANKS*3-1:0]       tank_dir;
   logic [NUM_TANKS*COORD_W-1:0] bullet_x;
   logic [NUM_TANKS*COORD_W-1:0] bullet_y;
   logic [NUM_TANKS*3-1:0]       bullet_dir;
   logic                         busy;
   logic                         done;
   logic [NUM_TANKS-1:0]         can_move;
   logic [NUM_TANKS-1:0]         bullet_hit;
   logic [NUM_TANKS-1:0]         tank_alive;

   modport master (
      output frame_start, round_clear, wall_x, wall_y, wall_vert,
             tank_x, tank_y, tank_dir, bullet_x, bullet_y, bullet_dir,
      input  busy, done, can_move, bullet_hit, tank_alive
   );

   modport slave (
      input  frame_start, round_clear, wall_x, wall_y, wall_vert,
             tank_x, tank_y, tank_dir, bullet_x, bullet_y, bullet_dir,
      output busy, done, can_move, bullet_hit, tank_alive
   );
endinterface

// File: rtl/collision_engine.sv
// ----------------------------------------------------------------------------
// collision_engine
// Sequential collision resolver for the tank game. A frame_start pulse
// snapshots every position, then one wall per cycle is tested against all
// tanks and bullets (screen edges folded into the first wall cycle), then one
// bullet per cycle is tested against all tanks. Results are published as
// registered outputs together with a one-cycle done pulse.
// Ports:
//   Clk      : system clock
//   Reset_n  : asynchronous active-low reset
//   bus      : collision_engine_if.slave (strobes, positions, results)
// ----------------------------------------------------------------------------
module collision_engine #(
   parameter int NUM_TANKS   = 2,
   parameter int NUM_WALLS   = 4,
   parameter int COORD_W     = 10,
   parameter int TANK_SIZE   = 32,
   parameter int BULLET_SIZE = 8,
   parameter int TANK_STEP   = 1,
   parameter int BULLET_STEP = 5,
   parameter int SCREEN_W    = 640,
   parameter int SCREEN_H    = 480
) (
   input logic               Clk,
   input logic               Reset_n,
   collision_engine_if.slave bus
);

   // One extra bit so sums never wrap, one more for the sign of x-step / y-step.
   localparam int SW     = COORD_W + 2;
   localparam int MAX_N  = (NUM_WALLS > NUM_TANKS) ? NUM_WALLS : NUM_TANKS;
   localparam int IDX_W  = (MAX_N > 1) ? $clog2(MAX_N) : 1;

   typedef logic signed [SW-1:0] scoord_t;
   typedef enum logic [1:0] {IDLE, WALL, PAIR, DONE} state_t;

   // ------------------------------------------------------------------------
   // Geometry helpers
   // ------------------------------------------------------------------------
   function automatic scoord_t widen(input logic [COORD_W-1:0] c);
      return scoord_t'({2'b00, c});
   endfunction

   function automatic logic dir_active(input logic [2:0] dir);
      return (dir >= 3'd1) && (dir <= 3'd4);
   endfunction

   function automatic scoord_t step_x(input scoord_t x, input logic [2:0] dir, input int step);
      case (dir)
         3'd2:    return x + scoord_t'(step);
         3'd3:    return x - scoord_t'(step);
         default: return x;
      endcase
   endfunction

   function automatic scoord_t step_y(input scoord_t y, input logic [2:0] dir, input int step);
      case (dir)
         3'd1:    return y - scoord_t'(step);
         3'd4:    return y + scoord_t'(step);
         default: return y;
      endcase
   endfunction

   // Strict inequalities: boxes that merely share an edge do not overlap.
   function automatic logic overlap(input scoord_t ax, input scoord_t ay,
                                    input scoord_t aw, input scoord_t ah,
                                    input scoord_t bx, input scoord_t by,
                                    input scoord_t bw, input scoord_t bh);
      return (ax < bx + bw) && (bx < ax + aw) && (ay < by + bh) && (by < ay + ah);
   endfunction

   function automatic logic off_screen(input scoord_t nx, input scoord_t ny, input int size);
      return (nx < scoord_t'(0)) || (ny < scoord_t'(0)) ||
             (nx + scoord_t'(size) > scoord_t'(SCREEN_W)) ||
             (ny + scoord_t'(size) > scoord_t'(SCREEN_H));
   endfunction

   // ------------------------------------------------------------------------
   // State, snapshot, accumulator and output registers
   // ------------------------------------------------------------------------
   state_t                       state_q, state_d;
   logic [IDX_W-1:0]             idx_q, idx_d;
   logic [NUM_WALLS*COORD_W-1:0] wall_x_q, wall_x_d, wall_y_q, wall_y_d;
   logic [NUM_WALLS-1:0]         wall_vert_q, wall_vert_d;
   logic [NUM_TANKS*COORD_W-1:0] tank_x_q, tank_x_d, tank_y_q, tank_y_d;
   logic [NUM_TANKS*COORD_W-1:0] bullet_x_q, bullet_x_d, bullet_y_q, bullet_y_d;
   logic [NUM_TANKS*3-1:0]       tank_dir_q, tank_dir_d, bullet_dir_q, bullet_dir_d;
   logic [NUM_TANKS-1:0]         alive_snap_q, alive_snap_d;
   logic [NUM_TANKS-1:0]         blk_q, blk_d;
   logic [NUM_TANKS-1:0]         hit_q, hit_d;
   logic [NUM_TANKS-1:0]         kill_q, kill_d;
   logic [NUM_TANKS-1:0]         can_move_q, can_move_d;
   logic [NUM_TANKS-1:0]         bullet_hit_q, bullet_hit_d;
   logic [NUM_TANKS-1:0]         tank_alive_q, tank_alive_d;

   // FSM control decodes
   logic snap_en, wall_en, pair_en, load_en;
   logic last_wall, last_tank;

   // Decoded geometry of the snapshot
   scoord_t tcx [NUM_TANKS];
   scoord_t tcy [NUM_TANKS];
   scoord_t tnx [NUM_TANKS];
   scoord_t tny [NUM_TANKS];
   scoord_t bnx [NUM_TANKS];
   scoord_t bny [NUM_TANKS];
   logic [NUM_TANKS-1:0] t_act, b_act;
   scoord_t wx, wy, ww, wh;
   scoord_t sbx, sby;
   logic    s_act;
   logic    pair_hit;

   assign last_wall = (int'(idx_q) == NUM_WALLS - 1);
   assign last_tank = (int'(idx_q) == NUM_TANKS - 1);

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // FSM: next state. frame_start is only honoured in IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.frame_start) state_d = WALL;
         WALL:    if (last_wall)       state_d = PAIR;
         PAIR:    if (last_tank)       state_d = DONE;
         DONE:                         state_d = IDLE;
         default:                      state_d = IDLE;
      endcase
   end

   // FSM: outputs. The results are loaded on the edge that enters DONE, so
   // during the DONE cycle done is high and the outputs already hold them.
   always_comb begin
      snap_en  = (state_q == IDLE) && bus.frame_start;
      wall_en  = (state_q == WALL);
      pair_en  = (state_q == PAIR);
      load_en  = (state_q == PAIR) && last_tank;
      bus.busy = (state_q == WALL) || (state_q == PAIR);
      bus.done = (state_q == DONE);
   end

   // ------------------------------------------------------------------------
   // Geometry decode of the snapshot and of the currently indexed wall/bullet
   // ------------------------------------------------------------------------
   always_comb begin
      for (int k = 0; k < NUM_TANKS; k++) begin
         tcx[k]   = widen(tank_x_q[k*COORD_W +: COORD_W]);
         tcy[k]   = widen(tank_y_q[k*COORD_W +: COORD_W]);
         tnx[k]   = step_x(tcx[k], tank_dir_q[k*3 +: 3], TANK_STEP);
         tny[k]   = step_y(tcy[k], tank_dir_q[k*3 +: 3], TANK_STEP);
         bnx[k]   = step_x(widen(bullet_x_q[k*COORD_W +: COORD_W]), bullet_dir_q[k*3 +: 3], BULLET_STEP);
         bny[k]   = step_y(widen(bullet_y_q[k*COORD_W +: COORD_W]), bullet_dir_q[k*3 +: 3], BULLET_STEP);
         t_act[k] = dir_active(tank_dir_q[k*3 +: 3]);
         b_act[k] = dir_active(bullet_dir_q[k*3 +: 3]);
      end
      wx = '0;
      wy = '0;
      ww = '0;
      wh = '0;
      for (int w = 0; w < NUM_WALLS; w++) begin
         if (int'(idx_q) == w) begin
            wx = widen(wall_x_q[w*COORD_W +: COORD_W]);
            wy = widen(wall_y_q[w*COORD_W +: COORD_W]);
            ww = wall_vert_q[w] ? scoord_t'(32) : scoord_t'(64);
            wh = wall_vert_q[w] ? scoord_t'(64) : scoord_t'(32);
         end
      end
      sbx   = '0;
      sby   = '0;
      s_act = 1'b0;
      for (int k = 0; k < NUM_TANKS; k++) begin
         if (int'(idx_q) == k) begin
            sbx   = bnx[k];
            sby   = bny[k];
            s_act = b_act[k];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Datapath next-state: snapshot, accumulate, publish
   // ------------------------------------------------------------------------
   always_comb begin
      idx_d        = idx_q;
      wall_x_d     = wall_x_q;
      wall_y_d     = wall_y_q;
      wall_vert_d  = wall_vert_q;
      tank_x_d     = tank_x_q;
      tank_y_d     = tank_y_q;
      tank_dir_d   = tank_dir_q;
      bullet_x_d   = bullet_x_q;
      bullet_y_d   = bullet_y_q;
      bullet_dir_d = bullet_dir_q;
      alive_snap_d = alive_snap_q;
      blk_d        = blk_q;
      hit_d        = hit_q;
      kill_d       = kill_q;
      can_move_d   = can_move_q;
      bullet_hit_d = bullet_hit_q;
      tank_alive_d = tank_alive_q;
      pair_hit     = 1'b0;

      if (snap_en) begin
         wall_x_d     = bus.wall_x;
         wall_y_d     = bus.wall_y;
         wall_vert_d  = bus.wall_vert;
         tank_x_d     = bus.tank_x;
         tank_y_d     = bus.tank_y;
         tank_dir_d   = bus.tank_dir;
         bullet_x_d   = bus.bullet_x;
         bullet_y_d   = bus.bullet_y;
         bullet_dir_d = bus.bullet_dir;
         alive_snap_d = tank_alive_q;
         idx_d        = '0;
         blk_d        = '0;
         hit_d        = '0;
         kill_d       = '0;
      end

      if (wall_en) begin
         for (int k = 0; k < NUM_TANKS; k++) begin
            if (t_act[k] &&
                (overlap(tnx[k], tny[k], scoord_t'(TANK_SIZE), scoord_t'(TANK_SIZE), wx, wy, ww, wh) ||
                 ((idx_q == '0) && off_screen(tnx[k], tny[k], TANK_SIZE))))
               blk_d[k] = 1'b1;
            if (b_act[k] &&
                (overlap(bnx[k], bny[k], scoord_t'(BULLET_SIZE), scoord_t'(BULLET_SIZE), wx, wy, ww, wh) ||
                 ((idx_q == '0) && off_screen(bnx[k], bny[k], BULLET_SIZE))))
               hit_d[k] = 1'b1;
         end
         idx_d = last_wall ? '0 : idx_q + IDX_W'(1);
      end

      if (pair_en) begin
         // Bullet idx against every live tank except its owner.
         for (int j = 0; j < NUM_TANKS; j++) begin
            if (s_act && (int'(idx_q) != j) && alive_snap_q[j] &&
                overlap(sbx, sby, scoord_t'(BULLET_SIZE), scoord_t'(BULLET_SIZE),
                        tcx[j], tcy[j], scoord_t'(TANK_SIZE), scoord_t'(TANK_SIZE))) begin
               kill_d[j] = 1'b1;
               pair_hit  = 1'b1;
            end
         end
         for (int k = 0; k < NUM_TANKS; k++)
            if (pair_hit && (int'(idx_q) == k)) hit_d[k] = 1'b1;
         idx_d = last_tank ? '0 : idx_q + IDX_W'(1);
      end

      // A tank killed this frame is already treated as dead for can_move.
      if (load_en) begin
         can_move_d   = alive_snap_q & ~kill_d & ~blk_d;
         bullet_hit_d = hit_d;
         tank_alive_d = tank_alive_q & ~kill_d;
      end

      if (bus.round_clear) tank_alive_d = '1;
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         idx_q        <= '0;
         wall_x_q     <= '0;
         wall_y_q     <= '0;
         wall_vert_q  <= '0;
         tank_x_q     <= '0;
         tank_y_q     <= '0;
         tank_dir_q   <= '0;
         bullet_x_q   <= '0;
         bullet_y_q   <= '0;
         bullet_dir_q <= '0;
         alive_snap_q <= '0;
         blk_q        <= '0;
         hit_q        <= '0;
         kill_q       <= '0;
         can_move_q   <= '1;
         bullet_hit_q <= '0;
         tank_alive_q <= '1;
      end else begin
         idx_q        <= idx_d;
         wall_x_q     <= wall_x_d;
         wall_y_q     <= wall_y_d;
         wall_vert_q  <= wall_vert_d;
         tank_x_q     <= tank_x_d;
         tank_y_q     <= tank_y_d;
         tank_dir_q   <= tank_dir_d;
         bullet_x_q   <= bullet_x_d;
         bullet_y_q   <= bullet_y_d;
         bullet_dir_q <= bullet_dir_d;
         alive_snap_q <= alive_snap_d;
         blk_q        <= blk_d;
         hit_q        <= hit_d;
         kill_q       <= kill_d;
         can_move_q   <= can_move_d;
         bullet_hit_q <= bullet_hit_d;
         tank_alive_q <= tank_alive_d;
      end
   end

   assign bus.can_move   = can_move_q;
   assign bus.bullet_hit = bullet_hit_q;
   assign bus.tank_alive = tank_alive_q;

endmodule

// File: tb/tb_collision_engine.sv
// ----------------------------------------------------------------------------
// tb_collision_engine
// Directed bench for collision_engine: a default 2-tank/4-wall instance and a
// 4-tank/8-wall instance share clock and reset. Expected values are worked
// out by hand from the box geometry and written inline.
// ----------------------------------------------------------------------------
module tb_collision_engine;

   logic clk;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   collision_engine_if #(.NUM_TANKS(2), .NUM_WALLS(4), .COORD_W(10)) bus_a ();
   collision_engine_if #(.NUM_TANKS(4), .NUM_WALLS(8), .COORD_W(10)) bus_b ();

   collision_engine #(.NUM_TANKS(2), .NUM_WALLS(4)) dut_a (
      .Clk(clk), .Reset_n(rst_n), .bus(bus_a));
   collision_engine #(.NUM_TANKS(4), .NUM_WALLS(8)) dut_b (
      .Clk(clk), .Reset_n(rst_n), .bus(bus_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_wall_a(input int w, input int x, input int y, input bit v);
      bus_a.wall_x[w*10 +: 10] = 10'(x);
      bus_a.wall_y[w*10 +: 10] = 10'(y);
      bus_a.wall_vert[w]       = v;
   endtask

   task automatic set_tank_a(input int k, input int x, input int y, input int d);
      bus_a.tank_x[k*10 +: 10] = 10'(x);
      bus_a.tank_y[k*10 +: 10] = 10'(y);
      bus_a.tank_dir[k*3 +: 3] = 3'(d);
   endtask

   task automatic set_bul_a(input int k, input int x, input int y, input int d);
      bus_a.bullet_x[k*10 +: 10] = 10'(x);
      bus_a.bullet_y[k*10 +: 10] = 10'(y);
      bus_a.bullet_dir[k*3 +: 3] = 3'(d);
   endtask

   task automatic set_tank_b(input int k, input int x, input int y, input int d);
      bus_b.tank_x[k*10 +: 10] = 10'(x);
      bus_b.tank_y[k*10 +: 10] = 10'(y);
      bus_b.tank_dir[k*3 +: 3] = 3'(d);
   endtask

   task automatic set_bul_b(input int k, input int x, input int y, input int d);
      bus_b.bullet_x[k*10 +: 10] = 10'(x);
      bus_b.bullet_y[k*10 +: 10] = 10'(y);
      bus_b.bullet_dir[k*3 +: 3] = 3'(d);
   endtask

   // Walls parked in the bottom-right corner, clear of every test object.
   task automatic park_walls_a();
      for (int w = 0; w < 4; w++) set_wall_a(w, 560, 440, 1'b0);
   endtask

   // Pulse frame_start on one DUT (cycle 0) and watch done for a bounded
   // number of cycles; cycle c is the one following the c-th rising edge.
   task automatic run_frame(input bit sel, input int budget, output int first, output int cnt);
      first = -1;
      cnt   = 0;
      @(negedge clk);
      if (sel) bus_b.frame_start = 1'b1;
      else     bus_a.frame_start = 1'b1;
      for (int c = 1; c <= budget; c++) begin
         @(posedge clk);
         @(negedge clk);
         bus_a.frame_start = 1'b0;
         bus_b.frame_start = 1'b0;
         if ((sel ? bus_b.done : bus_a.done) === 1'b1) begin
            cnt++;
            if (first < 0) first = c;
         end
      end
   endtask

   initial begin
      int first, cnt;
      logic busy_seen;

      rst_n = 1'b0;
      bus_a.frame_start = 1'b0;  bus_a.round_clear = 1'b0;
      bus_b.frame_start = 1'b0;  bus_b.round_clear = 1'b0;
      bus_a.wall_x = '0; bus_a.wall_y = '0; bus_a.wall_vert = '0;
      bus_a.tank_x = '0; bus_a.tank_y = '0; bus_a.tank_dir = '0;
      bus_a.bullet_x = '0; bus_a.bullet_y = '0; bus_a.bullet_dir = '0;
      bus_b.wall_x = '0; bus_b.wall_y = '0; bus_b.wall_vert = '0;
      bus_b.tank_x = '0; bus_b.tank_y = '0; bus_b.tank_dir = '0;
      bus_b.bullet_x = '0; bus_b.bullet_y = '0; bus_b.bullet_dir = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Reset state
      check("rst_busy",     32'(bus_a.busy),       32'd0);
      check("rst_done",     32'(bus_a.done),       32'd0);
      check("rst_can_move", 32'(bus_a.can_move),   32'h3);
      check("rst_hit",      32'(bus_a.bullet_hit), 32'h0);
      check("rst_alive",    32'(bus_a.tank_alive), 32'h3);
      check("rst_alive_b",  32'(bus_b.tank_alive), 32'hf);

      // Quiet frame: nothing moves
      park_walls_a();
      set_tank_a(0, 300, 300, 0);  set_tank_a(1, 400, 100, 0);
      set_bul_a(0, 50, 50, 0);     set_bul_a(1, 60, 60, 0);
      run_frame(1'b0, 16, first, cnt);
      check("quiet_done_cycle", 32'(first), 32'd7);
      check("quiet_done_count", 32'(cnt),   32'd1);
      check("quiet_can_move",   32'(bus_a.can_move),   32'h3);
      check("quiet_hit",        32'(bus_a.bullet_hit), 32'h0);
      check("quiet_alive",      32'(bus_a.tank_alive), 32'h3);

      // Horizontal wall at (100,100): overlap by one pixel, then edge touch
      set_wall_a(0, 100, 100, 1'b0);
      set_tank_a(0, 110, 132, 1);
      set_tank_a(1, 300, 300, 0);
      run_frame(1'b0, 16, first, cnt);
      check("wall_overlap_can_move", 32'(bus_a.can_move), 32'h2);
      set_tank_a(0, 110, 133, 1);
      run_frame(1'b0, 16, first, cnt);
      check("wall_touch_can_move", 32'(bus_a.can_move), 32'h3);

      // Screen edges: tank1 leaves left, tank0 reaches right edge exactly,
      // bullet0 leaves right, bullet1 reaches right edge exactly
      set_tank_a(0, 607, 300, 2);
      set_tank_a(1, 0, 200, 3);
      set_bul_a(0, 636, 50, 2);
      set_bul_a(1, 627, 50, 2);
      run_frame(1'b0, 16, first, cnt);
      check("edge_can_move", 32'(bus_a.can_move),   32'h1);
      check("edge_hit",      32'(bus_a.bullet_hit), 32'h1);
      check("edge_alive",    32'(bus_a.tank_alive), 32'h3);

      // Bullet0 hits tank1; it also overlaps its own tank0, which is immune
      park_walls_a();
      set_tank_a(0, 196, 300, 0);
      set_tank_a(1, 210, 296, 0);
      set_bul_a(0, 200, 300, 2);
      set_bul_a(1, 60, 60, 0);
      run_frame(1'b0, 16, first, cnt);
      check("kill_hit",      32'(bus_a.bullet_hit), 32'h1);
      check("kill_alive",    32'(bus_a.tank_alive), 32'h1);
      check("kill_can_move", 32'(bus_a.can_move),   32'h1);

      // Same scene three more frames: dead tank1 is no longer a target
      for (int f = 0; f < 3; f++) begin
         run_frame(1'b0, 16, first, cnt);
         check("dead_alive_hold", 32'(bus_a.tank_alive), 32'h1);
         check("dead_not_target", 32'(bus_a.bullet_hit), 32'h0);
         check("dead_can_move",   32'(bus_a.can_move),   32'h1);
      end

      @(negedge clk) bus_a.round_clear = 1'b1;
      @(negedge clk) bus_a.round_clear = 1'b0;
      check("round_clear_alive", 32'(bus_a.tank_alive), 32'h3);

      // frame_start re-pulsed in cycles 2 and 5 is ignored
      set_tank_a(0, 300, 300, 0);  set_tank_a(1, 400, 100, 0);
      set_bul_a(0, 50, 50, 0);
      first = -1;
      cnt = 0;
      busy_seen = 1'b0;
      @(negedge clk) bus_a.frame_start = 1'b1;
      for (int c = 1; c <= 16; c++) begin
         @(posedge clk);
         @(negedge clk);
         bus_a.frame_start = (c == 2) || (c == 5);
         if (c == 1) busy_seen = bus_a.busy;
         if (bus_a.done === 1'b1) begin
            cnt++;
            if (first < 0) first = c;
         end
      end
      check("repulse_busy_c1",    32'(busy_seen),  32'd1);
      check("repulse_done_cycle", 32'(first),      32'd7);
      check("repulse_done_count", 32'(cnt),        32'd1);
      check("repulse_idle_busy",  32'(bus_a.busy), 32'd0);

      // Build non-reset outputs, then reset in cycle 4 of the next frame
      set_tank_a(0, 196, 300, 0);
      set_tank_a(1, 210, 296, 3);
      set_bul_a(0, 200, 300, 2);
      run_frame(1'b0, 16, first, cnt);
      check("prereset_alive", 32'(bus_a.tank_alive), 32'h1);
      check("prereset_hit",   32'(bus_a.bullet_hit), 32'h1);
      cnt = 0;
      @(negedge clk) bus_a.frame_start = 1'b1;
      for (int c = 1; c <= 16; c++) begin
         @(posedge clk);
         @(negedge clk);
         bus_a.frame_start = 1'b0;
         rst_n = (c != 4);
         if (bus_a.done === 1'b1) cnt++;
      end
      check("abort_no_done",   32'(cnt),              32'd0);
      check("abort_busy",      32'(bus_a.busy),       32'd0);
      check("abort_can_move",  32'(bus_a.can_move),   32'h3);
      check("abort_hit",       32'(bus_a.bullet_hit), 32'h0);
      check("abort_alive",     32'(bus_a.tank_alive), 32'h3);

      // 4 tanks / 8 walls instance
      for (int w = 0; w < 8; w++) begin
         bus_b.wall_x[w*10 +: 10] = 10'd560;
         bus_b.wall_y[w*10 +: 10] = 10'd440;
      end
      set_tank_b(0, 20, 20, 0);    set_tank_b(1, 200, 20, 0);
      set_tank_b(2, 100, 100, 0);  set_tank_b(3, 300, 300, 0);
      set_bul_b(0, 500, 200, 0);   set_bul_b(1, 500, 220, 0);
      set_bul_b(2, 110, 110, 1);   set_bul_b(3, 500, 240, 0);
      run_frame(1'b1, 24, first, cnt);
      check("b_done_cycle",  32'(first),              32'd13);
      check("b_done_count",  32'(cnt),                32'd1);
      check("b_own_hit",     32'(bus_b.bullet_hit),   32'h0);
      check("b_own_alive",   32'(bus_b.tank_alive),   32'hf);
      set_bul_b(2, 310, 310, 1);
      run_frame(1'b1, 24, first, cnt);
      check("b_kill_hit",      32'(bus_b.bullet_hit), 32'h4);
      check("b_kill_alive",    32'(bus_b.tank_alive), 32'h7);
      check("b_kill_can_move", 32'(bus_b.can_move),   32'h7);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
